// File: rtl/alu_sequencer.sv
// Instruction fetch/decode/execute controller for the 8-bit ALU datapath.
// Owns the program counter and drives ALU, register-file and accumulator strobes.
module alu_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [7:0]        instr_data,
    output logic [3:0]        alu_select,
    output logic [1:0]        alu_num_rotate,
    output logic [1:0]        rf_addr,
    output logic              rf_we,
    output logic              acc_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    localparam logic [3:0]        OP_LAST_ALU = 4'h9;
    localparam logic [3:0]        OP_STA      = 4'hA;
    localparam logic [3:0]        OP_HALT     = 4'hF;
    localparam logic [ADDR_W-1:0] PC_START    = ADDR_W'(START_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [3:0] opcode;
    assign opcode = ir_q[7:4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_START;
            ir_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        err_d          = err_q;
        done_d         = 1'b0;
        instr_req      = 1'b0;
        alu_select     = 4'd0;
        alu_num_rotate = 2'd0;
        rf_addr        = 2'd0;
        rf_we          = 1'b0;
        acc_we         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    pc_d    = PC_START;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (instr_ack) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rf_addr = ir_q[3:2];
                state_d = abort ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                rf_addr        = ir_q[3:2];
                alu_num_rotate = ir_q[1:0];
                if (opcode <= OP_LAST_ALU) begin
                    alu_select = opcode;
                end
                // abort wins over every EXEC action, including the strobes
                if (abort) begin
                    state_d = S_IDLE;
                end else if (opcode <= OP_LAST_ALU || opcode == OP_STA) begin
                    acc_we  = (opcode != OP_STA);
                    rf_we   = (opcode == OP_STA);
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_addr = pc_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
